mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine. It is the producer of dataR for the MEM/WB register.
//  - Takes one memory op per instruction from EX/MEM.
//  - Runs a req/gnt/rvalid handshake with a variable-latency data bus.
//  - Formats byte/half/word data: store lane steering, load sign/zero extension.
//  - Holds stall_mem high until the result is ready.
// PARAMETERS
//  TIMEOUT_CYC  255  watchdog limit in cycles across REQ+WAIT (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  mem_read_exe   in   1   load request from EX/MEM
//  mem_write_exe  in   1   store request from EX/MEM (never high together with mem_read_exe)
//  funct3_exe     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr_exe       in   32  byte address (ALU result)
//  wdata_exe      in   32  store data, right-aligned
//  stall_mem      out  1   freeze the PC, IF/ID, ID/EX and EX/MEM stages
//  dataR          out  32  formatted load data to MEM/WB
//  misalign_err   out  1   one-cycle pulse in DONE: misaligned access or illegal funct3
//  access_err     out  1   one-cycle pulse in DONE: bus timeout (MEM_TIMEOUT_EN only, else tied 0)
//  bus_req        out  1   request valid; held high until bus_gnt
//  bus_we         out  1   1 = write
//  bus_addr       out  32  word address, {addr_exe[31:2],2'b00}
//  bus_be         out  4   byte enables
//  bus_wdata      out  32  lane-replicated store data
//  bus_gnt        in   1   request accepted
//  bus_rvalid     in   1   read data valid / write acknowledge; arrives >=1 cycle after gnt
//  bus_rdata      in   32  read word
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata,
//    dataR, misalign_err, access_err. Watchdog counter = 0.
//  - FSM states: IDLE, REQ, WAIT, DONE.
//  - IDLE, op present (mem_read_exe|mem_write_exe):
//    - Legal and aligned: go to REQ. bus_* outputs are registered on this edge.
//    - Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3:
//      go to DONE with misalign_err=1 and dataR=0. No bus activity.
//  - IDLE, no op: stay. bus_rvalid and bus_gnt are ignored in IDLE.
//  - REQ: bus_req=1 and all bus_* outputs stable. On bus_gnt go to WAIT and drop bus_req.
//  - WAIT: on bus_rvalid go to DONE.
//    - Load: dataR <= formatted bus_rdata.
//    - Store: dataR <= 0.
//  - DONE: one cycle. The pipeline advances and MEM/WB captures dataR. Go to IDLE
//    unconditionally; the op inputs are ignored in DONE because they still belong to the
//    retiring instruction.
//  - stall_mem (combinational) = (state==REQ) | (state==WAIT) | (state==IDLE & op present).
//  - Minimum latency, IDLE to DONE = 3 cycles (gnt in the first REQ cycle, rvalid in the
//    first WAIT cycle). stall_mem is high for those 3 cycles and low in DONE.
//  - Load formatting: lane = addr[1:0] (B) or addr[1] (H).
//    - B / H: sign-extend.
//    - BU / HU: zero-extend.
//    - W: pass through.
//  - Store steering:
//    - SB: be = 0001<<addr[1:0], wdata = {4{wdata_exe[7:0]}}.
//    - SH: be = 0011<<addr[1:0], wdata = {2{wdata_exe[15:0]}}.
//    - SW: be = 1111.
//    - Loads: bus_be = 1111, bus_we = 0.
//  - dataR holds its value outside DONE until the next completion.
//  - Reset mid-transaction: abort immediately. bus_req drops and the FSM enters IDLE.
//    A late bus_rvalid is ignored.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - An 8-bit+ counter runs in REQ and WAIT and clears on entry to REQ.
//    - When it reaches TIMEOUT_CYC: go to DONE with access_err=1, dataR=0, bus_req=0.
//  - MEM_TIMEOUT_EN undefined: no counter; REQ and WAIT wait forever; access_err tied 0.
// TESTING
//  1. LW addr=0x100, gnt in 1st REQ cycle, rvalid in 1st WAIT cycle, rdata=0xDEADBEEF
//     -> stall high 3 cycles; DONE: dataR=0xDEADBEEF, no errors.
//  2. LB addr=0x103, rdata=0x80FF_FFFF -> be=1111, dataR=0xFFFFFF80.
//     LBU same -> dataR=0x00000080.
//  3. SH addr=0x202, wdata_exe=0x1234ABCD -> bus_addr=0x200, be=1100,
//     bus_wdata=0xABCDABCD, we=1; gnt held off 4 cycles -> bus_req stays high, stall high.
//  4. LW addr=0x101 -> no bus_req; next cycle DONE, misalign_err=1, dataR=0.
//     funct3=011 -> same result.
//  5. rst pulse while in WAIT -> state IDLE, bus_req=0, outputs 0; later rvalid ignored
//     and stall_mem=0.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYC=8, gnt never asserted -> DONE after 8 cycles in REQ,
//     access_err=1, dataR=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM-stage access unit (master) and the
// variable-latency data memory (slave): req/gnt/rvalid handshake.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one bus transaction per memory op,
// steers store lanes, sign/zero-extends load data into dataR and holds
// stall_mem until the result is ready.
// Optional bus watchdog: define MEM_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_exe,
  input  logic        mem_write_exe,
  input  logic [2:0]  funct3_exe,
  input  logic [31:0] addr_exe,
  input  logic [31:0] wdata_exe,
  output logic        stall_mem,
  output logic [31:0] dataR,
  output logic        misalign_err,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        op_req;
  logic        f3_illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_fmt;

  assign op_req     = mem_read_exe | mem_write_exe;
  assign f3_illegal = (funct3_exe == 3'b011) | (funct3_exe[2:1] == 2'b11);
  assign misaligned = ((funct3_exe[1:0] == 2'b01) & addr_exe[0]) |
                      ((funct3_exe[1:0] == 2'b10) & (|addr_exe[1:0]));
  assign stall_mem  = (state == REQ) | (state == WAIT) | ((state == IDLE) & op_req);

  always_comb begin
    be_next    = '1;
    wdata_next = '0;
    if (mem_write_exe) begin
      case (funct3_exe[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr_exe[1:0];
          wdata_next = {4{wdata_exe[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << addr_exe[1:0];
          wdata_next = {2{wdata_exe[15:0]}};
        end
        default: wdata_next = wdata_exe;
      endcase
    end
  end

  always_comb begin
    case (op_lane)
      2'd0:    rbyte = bus_rdata[7:0];
      2'd1:    rbyte = bus_rdata[15:8];
      2'd2:    rbyte = bus_rdata[23:16];
      default: rbyte = bus_rdata[31:24];
    endcase
    rhalf = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_f3)
      3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_fmt = {24'd0, rbyte};
      3'b101:  load_fmt = {16'd0, rhalf};
      default: load_fmt = bus_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (state == IDLE)
      wd_cnt <= '0;
    else if ((state == REQ) || (state == WAIT))
      wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  assign access_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      dataR        <= '0;
      misalign_err <= 1'b0;
      op_we        <= 1'b0;
      op_f3        <= '0;
      op_lane      <= '0;
`ifdef MEM_TIMEOUT_EN
      access_err   <= 1'b0;
`endif
    end else begin
      misalign_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      access_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (op_req) begin
            if (f3_illegal | misaligned) begin
              state        <= DONE;
              misalign_err <= 1'b1;
              dataR        <= '0;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= mem_write_exe;
              bus_addr  <= {addr_exe[31:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= wdata_next;
              op_we     <= mem_write_exe;
              op_f3     <= funct3_exe;
              op_lane   <= addr_exe[1:0];
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            state   <= WAIT;
            bus_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            state <= DONE;
            dataR <= op_we ? '0 : load_fmt;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      // A handshake arriving in the final cycle still wins over the timeout.
      if (wd_expired && (((state == REQ) && !bus_gnt) ||
                         ((state == WAIT) && !bus_rvalid))) begin
        state      <= DONE;
        access_err <= 1'b1;
        dataR      <= '0;
        bus_req    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and randomized load/store ops
// against a behavioural model of formatting, steering and handshake timing.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_exe, mem_write_exe;
  logic [2:0]  funct3_exe;
  logic [31:0] addr_exe, wdata_exe;
  logic        stall_mem;
  logic [31:0] dataR;
  logic        misalign_err, access_err;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus();

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_exe (mem_read_exe),
    .mem_write_exe(mem_write_exe),
    .funct3_exe   (funct3_exe),
    .addr_exe     (addr_exe),
    .wdata_exe    (wdata_exe),
    .stall_mem    (stall_mem),
    .dataR        (dataR),
    .misalign_err (misalign_err),
    .access_err   (access_err),
    .bus_req      (bus.bus_req),
    .bus_we       (bus.bus_we),
    .bus_addr     (bus.bus_addr),
    .bus_be       (bus.bus_be),
    .bus_wdata    (bus.bus_wdata),
    .bus_gnt      (bus.bus_gnt),
    .bus_rvalid   (bus.bus_rvalid),
    .bus_rdata    (bus.bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return !legal || ((a % nbytes(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int unsigned n;
    longint v;
    longint span;
    n = nbytes(f3);
    v = longint'({32'd0, rdata >> (8 * (a % 4))});
    if (n < 4) begin
      span = longint'(1) << (8 * n);
      v = v % span;
      if (!f3[2] && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = nbytes(f3);
    if (!wr || n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Drive one op through IDLE -> (REQ -> WAIT) -> DONE -> IDLE, with gd cycles
  // of withheld grant and rd cycles of withheld rvalid.
  task automatic run_op(input string name, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] rdata);
    bit          is_bad;
    logic [31:0] exp_d;
    int          stall_cyc;
    is_bad = model_bad(f3, addr);
    exp_d  = (wr || is_bad) ? 32'd0 : model_load(f3, addr, rdata);
    mem_read_exe  = !wr;
    mem_write_exe = wr;
    funct3_exe    = f3;
    addr_exe      = addr;
    wdata_exe     = wd;
    #1;
    total++;
    if (stall_mem !== 1'b1) begin
      bad++; $display("FAIL %s stall_idle: got %b want 1", name, stall_mem);
    end
    stall_cyc = 1;
    step();
    if (is_bad) begin
      total++;
      if ({misalign_err, access_err, bus.bus_req, stall_mem, dataR} !== {4'b1000, 32'd0}) begin
        bad++;
        $display("FAIL %s misalign_done: got err=%b aerr=%b req=%b stall=%b data=%h want 1 0 0 0 0",
                 name, misalign_err, access_err, bus.bus_req, stall_mem, dataR);
      end
    end else begin
      total++;
      if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be} !==
          {1'b1, wr, addr & 32'hFFFF_FFFC, model_be(wr, f3, addr)}) begin
        bad++;
        $display("FAIL %s req_fields: got req=%b we=%b addr=%h be=%b want 1 %b %h %b", name,
                 bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, wr,
                 addr & 32'hFFFF_FFFC, model_be(wr, f3, addr));
      end
      if (wr) begin
        total++;
        if (bus.bus_wdata !== model_wdata(f3, wd)) begin
          bad++; $display("FAIL %s wdata: got %h want %h", name, bus.bus_wdata, model_wdata(f3, wd));
        end
      end
      for (int i = 0; i < gd; i++) begin
        if (stall_mem) stall_cyc++;
        step();
        total++;
        if (bus.bus_req !== 1'b1) begin
          bad++; $display("FAIL %s req_held: got %b want 1", name, bus.bus_req);
        end
      end
      if (stall_mem) stall_cyc++;
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt = 1'b0;
      total++;
      if (bus.bus_req !== 1'b0) begin
        bad++; $display("FAIL %s req_drop: got %b want 0", name, bus.bus_req);
      end
      for (int i = 0; i < rd; i++) begin
        if (stall_mem) stall_cyc++;
        bus.bus_rdata = $urandom;
        step();
      end
      if (stall_mem) stall_cyc++;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = rdata;
      step();
      bus.bus_rvalid = 1'b0;
      bus.bus_rdata  = $urandom;
      total++;
      if (stall_cyc !== gd + rd + 3) begin
        bad++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cyc, gd + rd + 3);
      end
      total++;
      if ({misalign_err, access_err, stall_mem, dataR} !== {3'b000, exp_d}) begin
        bad++;
        $display("FAIL %s done: got err=%b aerr=%b stall=%b data=%h want 0 0 0 %h",
                 name, misalign_err, access_err, stall_mem, dataR, exp_d);
      end
    end
    // Op inputs are still held through DONE; the unit must not restart on them.
    step();
    total++;
    if ({bus.bus_req, stall_mem, misalign_err, dataR} !== {3'b010, exp_d}) begin
      bad++;
      $display("FAIL %s after_done: got req=%b stall=%b err=%b data=%h want 0 1 0 %h",
               name, bus.bus_req, stall_mem, misalign_err, dataR, exp_d);
    end
    mem_read_exe  = 1'b0;
    mem_write_exe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read_exe = 1'b0; mem_write_exe = 1'b0;
    funct3_exe = '0; addr_exe = '0; wdata_exe = '0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    step();
    step();
    total++;
    if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata, dataR,
         misalign_err, access_err, stall_mem} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h data=%h err=%b aerr=%b stall=%b want all 0",
               bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata, dataR,
               misalign_err, access_err, stall_mem);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_op("lw_basic", 1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 0, 32'hDEAD_BEEF);
    run_op("lb_sign",  1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 0, 32'h80FF_FFFF);
    run_op("lbu_zero", 1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 2, 32'h80FF_FFFF);
    run_op("sh_held",  1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4, 0, 32'd0);
    run_op("lh_hi",    1'b0, 3'b001, 32'h0000_0012, 32'd0, 0, 1, 32'h8001_7FFF);
    run_op("lhu_hi",   1'b0, 3'b101, 32'h0000_0012, 32'd0, 2, 0, 32'h8001_7FFF);
    run_op("sb_lane1", 1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 0, 0, 32'd0);
    run_op("sw_full",  1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D, 1, 1, 32'd0);
  endtask

  task automatic test_misalign();
    run_op("lw_mis",   1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 0, 32'd0);
    run_op("f3_011",   1'b0, 3'b011, 32'h0000_0100, 32'd0, 0, 0, 32'd0);
    run_op("sh_mis",   1'b1, 3'b001, 32'h0000_0203, 32'hFFFF_FFFF, 0, 0, 32'd0);
    run_op("f3_110",   1'b0, 3'b110, 32'h0000_0100, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic test_reset_mid();
    mem_read_exe = 1'b1; funct3_exe = 3'b010; addr_exe = 32'h0000_0300;
    step();
    bus.bus_gnt = 1'b1;
    step();
    bus.bus_gnt = 1'b0;
    mem_read_exe = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.bus_req, bus.bus_addr, bus.bus_be, dataR, stall_mem} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got req=%b addr=%h be=%b data=%h stall=%b want all 0",
               bus.bus_req, bus.bus_addr, bus.bus_be, dataR, stall_mem);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.bus_rvalid = 1'b1;
    bus.bus_rdata  = 32'h1234_5678;
    step();
    bus.bus_rvalid = 1'b0;
    step();
    total++;
    if ({bus.bus_req, stall_mem, misalign_err, dataR} !== '0) begin
      bad++;
      $display("FAIL late_rvalid: got req=%b stall=%b err=%b data=%h want 0 0 0 0",
               bus.bus_req, stall_mem, misalign_err, dataR);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    bit          wr;
    for (int i = 0; i < 40; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 7))
          0, 1:    f3 = 3'b010;
          2:       f3 = 3'b000;
          3:       f3 = 3'b001;
          4:       f3 = 3'b100;
          5:       f3 = 3'b101;
          6:       f3 = 3'b000;
          default: f3 = 3'($urandom_range(6, 7));
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op("random", wr, f3, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_read_exe = 1'b1; funct3_exe = 3'b010; addr_exe = 32'h0000_0400;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (bus.bus_req !== 1'b1) begin
        bad++; $display("FAIL timeout_wait: got req=%b want 1", bus.bus_req);
      end
    end
    step();
    mem_read_exe = 1'b0;
    total++;
    if ({access_err, misalign_err, bus.bus_req, stall_mem, dataR} !== {4'b1000, 32'd0}) begin
      bad++;
      $display("FAIL timeout_done: got aerr=%b err=%b req=%b stall=%b data=%h want 1 0 0 0 0",
               access_err, misalign_err, bus.bus_req, stall_mem, dataR);
    end
    step();
    total++;
    if (access_err !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got %b want 0", access_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_reset_mid();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
